// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared 256-byte scratch memory.
// Latches one request at a time, sequences the write or two-cycle read, and returns done/rdata per port.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;    // 1 = favour B on a tie
  logic                port_q, port_d;  // port owning the current transaction (1 = B)
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic                drive_q, drive_d;
  logic                a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                a_done_q, a_done_d, b_done_q, b_done_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                busy_q, busy_d;
  logic                grant_a, grant_b, sel_we;

  assign grant_a = a_req && (!b_req || !ptr_q);
  assign grant_b = b_req && !grant_a;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    port_d      = port_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    drive_d     = 1'b0;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    sel_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          ptr_d      = ~ptr_q;
          port_d     = grant_b;
          a_gnt_d    = grant_a;
          b_gnt_d    = grant_b;
          sel_we     = grant_b ? b_we : a_we;
          mem_addr_d = grant_b ? b_addr : a_addr;
          wdata_d    = grant_b ? b_wdata : a_wdata;
          if (sel_we) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            drive_d     = 1'b1;
          end else begin
            state_d    = RD1;
            mem_read_d = 1'b1;
          end
        end
      end
      WR: begin
        state_d  = IDLE;
        a_done_d = !port_q;
        b_done_d = port_q;
      end
      RD1: begin
        state_d    = RD2;
        mem_read_d = 1'b1;
      end
      RD2: begin
        // Memory has been driving the bus for this whole cycle; sample it on the way out.
        state_d  = IDLE;
        a_done_d = !port_q;
        b_done_d = port_q;
        if (port_q) b_rdata_d = mem_data;
        else        a_rdata_d = mem_data;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      port_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      drive_q     <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      port_q      <= port_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      drive_q     <= drive_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Write data only matters while drive_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  assign mem_data  = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign mem_addr  = mem_addr_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected grants/results,
// a negedge monitor pops and checks them against the DUT and a behavioural memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  wire        a_gnt, a_done, b_gnt, b_done;
  wire  [7:0] a_rdata, b_rdata, mem_addr;
  wire  [7:0] mem_data;
  wire        mem_write, mem_read, busy;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write(mem_write), .mem_read(mem_read), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural memory: writes on the edge, reads register on the first edge then drive the bus.
  logic [7:0] mem [0:255];
  logic [7:0] mout_q;
  logic       men_q = 1'b0;
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data;
    if (mem_read) mout_q <= mem[mem_addr];
    men_q <= mem_read;
  end
  assign mem_data = (mem_read && !mem_write && men_q) ? mout_q : 8'bz;

  // With both strobes low nobody else may drive, so the bus must read back this probe value.
  assign mem_data = (!mem_write && !mem_read) ? 8'h00 : 8'bz;

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  bit   cur_vld = 1'b0;
  int   cyc = 0, gnt_cyc = 0, rd_run = 0;
  logic [7:0] mdl_a = 8'h00, mdl_b = 8'h00;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      cur_vld = 1'b0;
      mdl_a   = 8'h00;
      mdl_b   = 8'h00;
      rd_run  = 0;
    end else begin
      chk("strobe_exclusive", {31'b0, mem_write && mem_read}, 32'd0);
      chk("busy_tracks_strobes", {31'b0, busy}, {31'b0, mem_write || mem_read});
      if (!mem_write && !mem_read) chk("bus_released", {24'b0, mem_data}, 32'h00);
      if (mem_read) rd_run++;
      else begin
        if (rd_run != 0) chk("mem_read_len", rd_run, 32'd2);
        rd_run = 0;
      end
      if (a_gnt || b_gnt) begin
        chk("single_gnt", {31'b0, a_gnt && b_gnt}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_gnt", {31'b0, b_gnt}, 32'hFFFF_FFFF);
        else begin
          cur = exp_q.pop_front();
          chk("gnt_port", {31'b0, b_gnt}, {31'b0, cur.port});
          chk("gnt_addr", {24'b0, mem_addr}, {24'b0, cur.addr});
          chk("gnt_write", {31'b0, mem_write}, {31'b0, cur.we});
          chk("gnt_read", {31'b0, mem_read}, {31'b0, !cur.we});
          if (cur.we) chk("wr_bus_data", {24'b0, mem_data}, {24'b0, cur.data});
          cur_vld = 1'b1;
          gnt_cyc = cyc;
        end
      end
      if (a_done || b_done) begin
        chk("single_done", {31'b0, a_done && b_done}, 32'd0);
        if (!cur_vld) chk("unexpected_done", {31'b0, b_done}, 32'hFFFF_FFFF);
        else begin
          chk("done_port", {31'b0, b_done}, {31'b0, cur.port});
          chk("done_latency", cyc - gnt_cyc, cur.we ? 32'd1 : 32'd2);
          if (!cur.we) begin
            if (cur.port) mdl_b = cur.data;
            else          mdl_a = cur.data;
          end
          cur_vld = 1'b0;
        end
        chk("a_rdata", {24'b0, a_rdata}, {24'b0, mdl_a});
        chk("b_rdata", {24'b0, b_rdata}, {24'b0, mdl_b});
      end
    end
  end

  task automatic push_exp(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] data);
    txn_t e;
    e.port = port; e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] data);
    if (!port) begin a_we = we; a_addr = addr; a_wdata = we ? data : 8'h00; a_req = 1'b1; end
    else       begin b_we = we; b_addr = addr; b_wdata = we ? data : 8'h00; b_req = 1'b1; end
  endtask

  // Waits for done (bounded) and drops req inside the done cycle so no extra grant follows.
  task automatic wait_done(input bit port);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      seen = port ? b_done : a_done;
    end
    chk(port ? "b_done_seen" : "a_done_seen", {31'b0, seen}, 32'd1);
    if (!port) a_req = 1'b0;
    else       b_req = 1'b0;
  endtask

  task automatic wait_gnt(input bit port);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      seen = port ? b_gnt : a_gnt;
    end
    chk(port ? "b_gnt_seen" : "a_gnt_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic txn(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] data);
    push_exp(port, we, addr, data);
    drive(port, we, addr, data);
    wait_done(port);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'h00);
    chk("rst_bus", {24'b0, mem_data}, 32'h00);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_gnt", {30'b0, a_gnt, b_gnt}, 32'd0);
    chk("rst_done", {30'b0, a_done, b_done}, 32'd0);
    chk("rst_rdata", {16'b0, a_rdata, b_rdata}, 32'h0000);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Saturated contention: strict A, B, A, B
    push_exp(1'b0, 1'b1, 8'h10, 8'h11);
    push_exp(1'b1, 1'b1, 8'h20, 8'h22);
    push_exp(1'b0, 1'b1, 8'h10, 8'h11);
    push_exp(1'b1, 1'b1, 8'h20, 8'h22);
    fork
      begin
        drive(1'b0, 1'b1, 8'h10, 8'h11); wait_done(1'b0);
        drive(1'b0, 1'b1, 8'h10, 8'h11); wait_done(1'b0);
      end
      begin
        drive(1'b1, 1'b1, 8'h20, 8'h22); wait_done(1'b1);
        drive(1'b1, 1'b1, 8'h20, 8'h22); wait_done(1'b1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Port A write then read back
    txn(1'b0, 1'b1, 8'h3C, 8'hA5);
    txn(1'b0, 1'b0, 8'h3C, 8'hA5);

    // A writes 0x10, B reads it; a_rdata must stay 0xA5
    txn(1'b0, 1'b1, 8'h10, 8'h5A);
    txn(1'b1, 1'b0, 8'h10, 8'h5A);

    // B read of 0x20 with address change and req drop one cycle after grant
    push_exp(1'b1, 1'b0, 8'h20, 8'h22);
    drive(1'b1, 1'b0, 8'h20, 8'h00);
    wait_gnt(1'b1);
    @(posedge clk); #1;
    b_addr = 8'h77;
    b_req  = 1'b0;
    wait_done(1'b1);
    chk("b_rdata_after_drop", {24'b0, b_rdata}, 32'h22);

    // Reset pulsed during RD2 of an A read
    push_exp(1'b0, 1'b0, 8'h3C, 8'hA5);
    drive(1'b0, 1'b0, 8'h3C, 8'h00);
    wait_gnt(1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    a_req = 1'b0;
    chk("rd2rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rd2rst_bus", {24'b0, mem_data}, 32'h00);
    chk("rd2rst_busy", {31'b0, busy}, 32'd0);
    chk("rd2rst_done", {30'b0, a_done, b_done}, 32'd0);
    chk("rd2rst_rdata", {16'b0, a_rdata, b_rdata}, 32'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rd2rst_done_hold", {30'b0, a_done, b_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // After reset the pointer favours A again
    push_exp(1'b0, 1'b1, 8'h40, 8'h44);
    push_exp(1'b1, 1'b0, 8'h3C, 8'hA5);
    drive(1'b0, 1'b1, 8'h40, 8'h44);
    drive(1'b1, 1'b0, 8'h3C, 8'h00);
    fork
      wait_done(1'b0);
      wait_done(1'b1);
    join

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("no_inflight", {31'b0, cur_vld}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the 256-byte shared scratch memory (8-bit address, bidirectional 8-bit data, separate write/read strobes).
- Sits between two requesters (port A: sensor sampler, port B: radio/host) and the memory.
- Latches each request, drives the memory strobes and the tri-state data bus with the correct turnaround, and returns completion and read data per port.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A request; held until a_done.
- a_we  input  1  port A: 1 = write, 0 = read.
- a_addr  input  ADDR_W  port A address.
- a_wdata  input  DATA_W  port A write data.
- a_gnt  output  1  one-cycle pulse when port A request is accepted.
- a_done  output  1  one-cycle pulse when port A transaction completes.
- a_rdata  output  DATA_W  port A read data; valid with a_done on reads, held until the next A read completes.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: identical set for port B.
- mem_addr  output  ADDR_W  memory address.
- mem_data  inout  DATA_W  memory data bus.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read strobe.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- All outputs registered. Reset (async assert, sync release) values:
  - state = IDLE; mem_write = mem_read = 0; mem_addr = 0; mem_data released (Z).
  - gnt/done = 0; rdata = 0; busy = 0.
  - Round-robin pointer favours A.
- Memory contract:
  - Write: captured on the rising edge while mem_write = 1.
  - Read: needs mem_read high for two cycles. The memory registers its output on the first edge and drives the bus while read && !write.
- States: IDLE, WR, RD1, RD2.
- IDLE:
  - No request pending: stay.
  - One request pending: grant it.
  - Both pending: grant the port not granted last (pointer toggles on every grant).
  - On grant edge: latch we/addr/wdata into internal registers, set mem_addr, pulse gnt_x for one cycle, go to WR (we = 1) or RD1 (we = 0).
  - mem_write/mem_read rise in the same cycle as gnt_x.
- WR:
  - mem_write = 1, mem_read = 0; controller drives mem_data = latched wdata.
  - Next edge: memory writes; mem_write -> 0, bus released, done_x pulses, go to IDLE.
- RD1:
  - mem_read = 1, bus Z.
  - Next edge: memory latches data; go to RD2.
- RD2:
  - mem_read stays 1; memory drives bus.
  - Next edge: rdata_x <= mem_data, done_x pulses, mem_read -> 0, go to IDLE.
- Latency from grant to done:
  - Write: done one cycle after gnt; 2 cycles per write including IDLE.
  - Read: done two cycles after gnt; 3 cycles per read including IDLE.
- Requests are re-evaluated only in IDLE. A requester keeping req high after done is re-arbitrated in the IDLE cycle that follows done. With both ports saturated, grants alternate strictly A, B, A, B.
- Inputs are latched at grant. Changing or dropping req/addr/wdata mid-transaction has no effect; the transaction completes and done still pulses.
- Invariants:
  - mem_write and mem_read never both 1.
  - Controller drives mem_data only in WR.
  - At most one gnt and one done per cycle; done_x only for the port last granted.
- Reset mid-transaction: immediate return to reset values, bus released, no done pulse. The interrupted write may or may not have landed; no guarantee is given.
- Address width: full range 0x00..0xFF; no wrap logic inside the block.

Test Plan:
- Reset then idle: rst_n low 3 cycles, no req -> all strobes 0, mem_data Z, busy 0, gnt/done never pulse.
- Port A write 0x3C <- 0xA5, then port A read 0x3C -> a_gnt, then a_done 1 cycle later; then read a_done 2 cycles after a_gnt with a_rdata = 0xA5; mem_read high exactly 2 cycles.
- a_req and b_req asserted together and held (A write 0x10 <- 0x11, B write 0x20 <- 0x22) -> grant order A, B, A, B; no port granted twice in a row while the other waits.
- B reads 0x10 after A writes 0x10 <- 0x5A -> b_rdata = 0x5A, a_rdata unchanged; no cycle with mem_write && mem_read or controller driving mem_data outside WR.
- Port B changes b_addr and drops b_req one cycle after b_gnt on a read of 0x20 -> transaction still reads 0x20, b_done pulses with the original data.
- rst_n pulsed low during RD2 -> mem_read 0 and bus Z immediately, no a_done/b_done, state IDLE; next request serviced normally with pointer favouring A.
